// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between the EX-stage pipeline (priority)
// and an external req/grant requester, with a starvation counter forcing a one-cycle stall.
module dmem_port_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int DATA_W       = 32
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              P_REQ,
    input  logic              P_MW,
    input  logic [DATA_W-1:0] P_ADDR,
    input  logic [DATA_W-1:0] P_DATAIN,
    output logic [DATA_W-1:0] P_DATAOUT,
    output logic              STALL,
    input  logic              X_REQ,
    input  logic              X_WE,
    input  logic [DATA_W-1:0] X_ADDR,
    input  logic [DATA_W-1:0] X_WDATA,
    output logic              X_GNT,
    output logic              X_RVALID,
    output logic [DATA_W-1:0] X_RDATA,
    output logic [DATA_W-1:0] MEM_ADDR,
    output logic              MEM_MW,
    output logic [DATA_W-1:0] MEM_DATAIN,
    input  logic [DATA_W-1:0] MEM_DATAOUT
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic {S_NORM, S_FORCE} state_t;

    state_t      state, next_state;
    logic [3:0]  starve_cnt, next_cnt, cnt_inc;
    logic        x_own, stall_int, gnt_int, mw_int;
    logic        rd_pend;

    // State and starvation counter registers
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state      <= S_NORM;
            starve_cnt <= '0;
        end else begin
            state      <= next_state;
            starve_cnt <= next_cnt;
        end
    end

    // Next state: count only cycles where X is denied because the pipeline holds the port
    always_comb begin
        next_state = S_NORM;
        next_cnt   = '0;
        cnt_inc    = starve_cnt + 4'd1;
        if (state == S_NORM && P_REQ && X_REQ) begin
            next_cnt = cnt_inc;
            if (cnt_inc == LIMIT) next_state = S_FORCE;
        end
    end

    // Outputs: in S_FORCE the pipeline is stalled, so it never writes even if X is absent
    always_comb begin
        x_own     = 1'b0;
        stall_int = 1'b0;
        case (state)
            S_NORM:  x_own = !P_REQ && X_REQ;
            S_FORCE: begin
                stall_int = 1'b1;
                x_own     = X_REQ;
            end
            default: x_own = 1'b0;
        endcase
        gnt_int = x_own;
        if (x_own)                mw_int = X_WE;
        else if (state == S_FORCE) mw_int = 1'b0;
        else                      mw_int = P_REQ & P_MW;
    end

    assign STALL      = stall_int & RESET;
    assign X_GNT      = gnt_int & RESET;
    assign MEM_MW     = mw_int & RESET;
    assign MEM_ADDR   = x_own ? X_ADDR  : P_ADDR;
    assign MEM_DATAIN = x_own ? X_WDATA : P_DATAIN;
    assign P_DATAOUT  = MEM_DATAOUT;

    // External read return: capture the registered memory data one cycle after grant
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            rd_pend  <= 1'b0;
            X_RVALID <= 1'b0;
            X_RDATA  <= '0;
        end else begin
            rd_pend  <= gnt_int & ~X_WE;
            X_RVALID <= rd_pend;
            if (rd_pend) X_RDATA <= MEM_DATAOUT;
        end
    end

endmodule
